// File: rtl/rf_host_arbiter.sv
// Shares the core register file with a host/debug port by stalling the core around one host access.
// Latency: request seen in RUN -> req_ready 2 cycles later -> rsp_valid the cycle after (3 minimum).
// Backpressure: host_rsp_ready low holds RESP (core stalled); a cool-down quantum spaces host grants.
module rf_host_arbiter #(
    parameter int DW          = 32,
    parameter int AW          = 5,
    parameter int CPU_QUANTUM = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_wR,
    input  logic [DW-1:0] cpu_wD,
    input  logic [AW-1:0] cpu_rR1,
    output logic          cpu_stall,
    output logic          rf_we,
    output logic [AW-1:0] rf_wR,
    output logic [DW-1:0] rf_wD,
    output logic [AW-1:0] rf_rR1,
    input  logic [DW-1:0] rf_rd1,
    input  logic          host_req_valid,
    input  logic          host_req_we,
    input  logic [AW-1:0] host_req_addr,
    input  logic [DW-1:0] host_req_wdata,
    output logic          host_req_ready,
    output logic          host_rsp_valid,
    output logic [DW-1:0] host_rsp_rdata,
    input  logic          host_rsp_ready
);

    localparam int CW = $clog2(CPU_QUANTUM + 1);
    localparam logic [CW-1:0] QUANTUM = CW'(CPU_QUANTUM);
    localparam logic [CW-1:0] CD_ONE  = CW'(1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cooldown_q, cooldown_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            cooldown_q  <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cooldown_q  <= cooldown_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Host-facing handshakes and the stall are pure decodes of the state register.
    assign cpu_stall      = (state_q != RUN);
    assign host_req_ready = (state_q == ACCESS);
    assign host_rsp_valid = (state_q == RESP);
    assign host_rsp_rdata = rsp_rdata_q;

    always_comb begin
        state_d     = state_q;
        cooldown_d  = cooldown_q;
        rsp_rdata_d = rsp_rdata_q;
        rf_we       = cpu_we;
        rf_wR       = cpu_wR;
        rf_wD       = cpu_wD;
        rf_rR1      = cpu_rR1;

        case (state_q)
            RUN: begin
                if (cooldown_q != '0) begin
                    cooldown_d = cooldown_q - CD_ONE;
                end
                // The deciding RUN cycle is itself an unstalled core cycle, so the grant
                // fires as the last quantum cycle is spent rather than one cycle later.
                if (host_req_valid && (cooldown_q <= CD_ONE)) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                rf_we   = 1'b0;
                state_d = host_req_valid ? ACCESS : RUN;
            end
            ACCESS: begin
                rf_rR1 = host_req_addr;
                if (host_req_we) begin
                    rf_we       = (host_req_addr != '0);
                    rf_wR       = host_req_addr;
                    rf_wD       = host_req_wdata;
                    rsp_rdata_d = '0;
                end else begin
                    rf_we       = 1'b0;
                    rsp_rdata_d = rf_rd1;
                end
                state_d = RESP;
            end
            RESP: begin
                rf_we = 1'b0;
                if (host_rsp_ready) begin
                    state_d    = RUN;
                    cooldown_d = QUANTUM;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_rf_host_arbiter.sv
// Bench for rf_host_arbiter: behavioural RF, randomized host traffic, register-content model.
module tb_rf_host_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int Q  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_we;
    logic [AW-1:0] cpu_wR, cpu_rR1;
    logic [DW-1:0] cpu_wD;
    logic          cpu_stall, rf_we;
    logic [AW-1:0] rf_wR, rf_rR1;
    logic [DW-1:0] rf_wD, rf_rd1;
    logic          host_req_valid, host_req_we, host_req_ready;
    logic [AW-1:0] host_req_addr;
    logic [DW-1:0] host_req_wdata, host_rsp_rdata;
    logic          host_rsp_valid, host_rsp_ready;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] rf_mem  [32];
    logic [DW-1:0] exp_mem [32];
    logic          rf_clr;

    rf_host_arbiter #(.DW(DW), .AW(AW), .CPU_QUANTUM(Q)) dut (
        .clk(clk), .rst(rst),
        .cpu_we(cpu_we), .cpu_wR(cpu_wR), .cpu_wD(cpu_wD), .cpu_rR1(cpu_rR1),
        .cpu_stall(cpu_stall),
        .rf_we(rf_we), .rf_wR(rf_wR), .rf_wD(rf_wD), .rf_rR1(rf_rR1), .rf_rd1(rf_rd1),
        .host_req_valid(host_req_valid), .host_req_we(host_req_we),
        .host_req_addr(host_req_addr), .host_req_wdata(host_req_wdata),
        .host_req_ready(host_req_ready),
        .host_rsp_valid(host_rsp_valid), .host_rsp_rdata(host_rsp_rdata),
        .host_rsp_ready(host_rsp_ready)
    );

    always #5 clk = ~clk;

    // Register file the arbiter fronts: x0 reads zero, combinational read, write on rising edge.
    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
        end else if (rf_we && rf_wR != '0) begin
            rf_mem[rf_wR] <= rf_wD;
        end
    end
    assign rf_rd1 = (rf_rR1 == '0) ? '0 : rf_mem[rf_rR1];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Drives one host request from the drive phase; with auto_rsp it accepts the response and
    // returns in the next drive phase, otherwise it returns at the negedge where rsp_valid was seen.
    task automatic host_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                            input bit auto_rsp, output logic [DW-1:0] rdata, output int t_ready,
                            output int t_rsp, output int n_run, output logic acc_we,
                            output logic [AW-1:0] acc_wr);
        int c;
        bit got;
        host_req_valid = 1'b1;
        host_req_we    = we;
        host_req_addr  = addr;
        host_req_wdata = wdata;
        t_ready = -1; t_rsp = -1; n_run = 0; rdata = '0; acc_we = 1'b0; acc_wr = '0;
        got = 1'b0;
        for (c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (!cpu_stall) n_run++;
            if (host_req_ready) begin
                got = 1'b1; t_ready = c; acc_we = rf_we; acc_wr = rf_wR;
            end
            step();
        end
        host_req_valid = 1'b0;
        if (!got) begin
            n_cmp++; n_err++;
            $display("FAIL txn_ready_timeout: no host_req_ready within 40 cycles (addr %0d)", addr);
            return;
        end
        got = 1'b0;
        for (c = t_ready + 1; c < t_ready + 40 && !got; c++) begin
            @(negedge clk);
            if (host_rsp_valid) begin
                got = 1'b1; t_rsp = c; rdata = host_rsp_rdata;
            end else begin
                step();
            end
        end
        if (!got) begin
            n_cmp++; n_err++;
            $display("FAIL txn_rsp_timeout: no host_rsp_valid within 40 cycles (addr %0d)", addr);
            step();
            return;
        end
        if (auto_rsp) begin
            host_rsp_ready = 1'b1;
            step();
            host_rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            cpu_we = 1'($urandom); cpu_wR = AW'($urandom); cpu_wD = $urandom; cpu_rR1 = AW'($urandom);
            host_req_valid = 1'b1; host_req_we = 1'($urandom); host_rsp_ready = 1'($urandom);
            host_req_addr = AW'($urandom); host_req_wdata = $urandom;
            @(posedge clk); #2;
            n_cmp++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b need 0", cpu_stall); end
            n_cmp++; if (host_req_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b need 0", host_req_ready); end
            n_cmp++; if (host_rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b need 0", host_rsp_valid); end
            n_cmp++; if (host_rsp_rdata !== '0) begin n_err++; $display("FAIL reset_rdata: got %h need 0", host_rsp_rdata); end
            n_cmp++; if ({rf_we, rf_wR, rf_wD, rf_rR1} !== {cpu_we, cpu_wR, cpu_wD, cpu_rR1}) begin
                n_err++; $display("FAIL reset_passthru: got we=%b wR=%0d wD=%h rR1=%0d need we=%b wR=%0d wD=%h rR1=%0d",
                                  rf_we, rf_wR, rf_wD, rf_rR1, cpu_we, cpu_wR, cpu_wD, cpu_rR1);
            end
        end
        @(negedge clk);
        cpu_we = 1'b0; host_req_valid = 1'b0; host_rsp_ready = 1'b0;
        rst = 1'b1; rf_clr = 1'b0;
        step();
    endtask

    task automatic test_write_read();
        logic [DW-1:0] rd; int tr, ts, nr; logic aw; logic [AW-1:0] ar;
        host_txn(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, rd, tr, ts, nr, aw, ar);
        exp_mem[5] = 32'hDEADBEEF;
        n_cmp++; if (tr !== 2) begin n_err++; $display("FAIL wr_ready_latency: got %0d need 2", tr); end
        n_cmp++; if (ts !== 3) begin n_err++; $display("FAIL wr_rsp_latency: got %0d need 3", ts); end
        n_cmp++; if (nr !== 1) begin n_err++; $display("FAIL wr_run_cycles: got %0d need 1", nr); end
        n_cmp++; if ({aw, ar} !== {1'b1, 5'd5}) begin n_err++; $display("FAIL wr_access_port: got we=%b wR=%0d need we=1 wR=5", aw, ar); end
        n_cmp++; if (rd !== '0) begin n_err++; $display("FAIL wr_rsp_rdata: got %h need 0", rd); end
        idle(Q);
        host_txn(1'b0, 5'd5, 32'h0, 1'b1, rd, tr, ts, nr, aw, ar);
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_x5: got %h need deadbeef", rd); end
        n_cmp++; if (aw !== 1'b0) begin n_err++; $display("FAIL rd_no_write: got rf_we=%b need 0", aw); end
    endtask

    task automatic test_x0();
        logic [DW-1:0] rd; int tr, ts, nr; logic aw; logic [AW-1:0] ar;
        idle(Q);
        host_txn(1'b1, 5'd0, 32'h1234, 1'b1, rd, tr, ts, nr, aw, ar);
        n_cmp++; if (aw !== 1'b0) begin n_err++; $display("FAIL x0_write_we: got %b need 0", aw); end
        n_cmp++; if (rd !== '0) begin n_err++; $display("FAIL x0_write_rdata: got %h need 0", rd); end
        n_cmp++; if (ts !== 3) begin n_err++; $display("FAIL x0_write_rsp: got %0d need 3", ts); end
        idle(Q);
        host_txn(1'b0, 5'd0, 32'h0, 1'b1, rd, tr, ts, nr, aw, ar);
        n_cmp++; if (rd !== '0) begin n_err++; $display("FAIL x0_read: got %h need 0", rd); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] rd, wd; int tr, ts, nr; logic aw; logic [AW-1:0] ar;
        wd = $urandom;
        idle(Q);
        host_txn(1'b1, 5'd9, wd, 1'b1, rd, tr, ts, nr, aw, ar);
        exp_mem[9] = wd;
        host_txn(1'b0, 5'd9, 32'h0, 1'b1, rd, tr, ts, nr, aw, ar);
        n_cmp++; if (nr !== Q) begin n_err++; $display("FAIL b2b_run_cycles: got %0d need %0d", nr, Q); end
        n_cmp++; if (tr !== Q + 1) begin n_err++; $display("FAIL b2b_ready_latency: got %0d need %0d", tr, Q + 1); end
        n_cmp++; if (ts !== Q + 2) begin n_err++; $display("FAIL b2b_rsp_latency: got %0d need %0d", ts, Q + 2); end
        n_cmp++; if (rd !== wd) begin n_err++; $display("FAIL b2b_rdata: got %h need %h", rd, wd); end
    endtask

    task automatic test_core_blocked();
        logic [DW-1:0] rd, a, b; int tr, ts, nr; logic aw; logic [AW-1:0] ar;
        a = $urandom; b = ~a;
        idle(Q);
        host_txn(1'b1, 5'd7, a, 1'b1, rd, tr, ts, nr, aw, ar);
        exp_mem[7] = a;
        idle(Q);
        host_req_valid = 1'b1; host_req_we = 1'b0; host_req_addr = 5'd7;
        step();
        cpu_we = 1'b1; cpu_wR = 5'd7; cpu_wD = b;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++; if ({cpu_stall, rf_we} !== 2'b10) begin
                n_err++; $display("FAIL blocked_stall_we[%0d]: got stall=%b we=%b need stall=1 we=0", c, cpu_stall, rf_we);
            end
            if (c == 1) begin
                n_cmp++; if (host_req_ready !== 1'b1) begin n_err++; $display("FAIL blocked_ready: got %b need 1", host_req_ready); end
            end
            if (c == 2) begin
                n_cmp++; if ({host_rsp_valid, host_rsp_rdata} !== {1'b1, a}) begin
                    n_err++; $display("FAIL blocked_rsp: got valid=%b rdata=%h need valid=1 rdata=%h", host_rsp_valid, host_rsp_rdata, a);
                end
                host_rsp_ready = 1'b1;
            end
            step();
            if (c == 1) host_req_valid = 1'b0;
        end
        host_rsp_ready = 1'b0;
        n_cmp++; if (rf_mem[7] !== a) begin n_err++; $display("FAIL blocked_x7_held: got %h need %h", rf_mem[7], a); end
        @(negedge clk);
        n_cmp++; if ({cpu_stall, rf_we} !== 2'b01) begin
            n_err++; $display("FAIL resume_we: got stall=%b we=%b need stall=0 we=1", cpu_stall, rf_we);
        end
        step();
        cpu_we = 1'b0;
        exp_mem[7] = b;
        n_cmp++; if (rf_mem[7] !== b) begin n_err++; $display("FAIL resume_x7_written: got %h need %h", rf_mem[7], b); end
        idle(Q);
        host_txn(1'b0, 5'd7, 32'h0, 1'b1, rd, tr, ts, nr, aw, ar);
        n_cmp++; if (rd !== exp_mem[7]) begin n_err++; $display("FAIL resume_x7_read: got %h need %h", rd, exp_mem[7]); end
    endtask

    task automatic test_random();
        logic [DW-1:0] rd, wd; int tr, ts, nr, g, need; logic aw, we; logic [AW-1:0] ar, addr;
        idle(Q);
        host_txn(1'b1, 5'd1, 32'h0BADF00D, 1'b1, rd, tr, ts, nr, aw, ar);
        exp_mem[1] = 32'h0BADF00D;
        for (int k = 0; k < 16; k++) begin
            g = $urandom_range(0, 6);
            we = 1'($urandom); addr = AW'($urandom); wd = $urandom;
            idle(g);
            host_txn(we, addr, wd, 1'b1, rd, tr, ts, nr, aw, ar);
            need = ((Q - g) > 1) ? (Q - g) : 1;
            n_cmp++; if (nr !== need) begin n_err++; $display("FAIL rnd_run_cycles[%0d]: got %0d need %0d (gap %0d)", k, nr, need, g); end
            n_cmp++; if (tr !== need + 1 || ts !== need + 2) begin
                n_err++; $display("FAIL rnd_latency[%0d]: got ready=%0d rsp=%0d need %0d/%0d", k, tr, ts, need + 1, need + 2);
            end
            if (we) begin
                n_cmp++; if ({aw, rd} !== {(addr != '0), {DW{1'b0}}}) begin
                    n_err++; $display("FAIL rnd_write[%0d]: got we=%b rdata=%h need we=%b rdata=0 (x%0d)", k, aw, rd, addr != '0, addr);
                end
                if (addr != '0) exp_mem[addr] = wd;
            end else begin
                n_cmp++; if (rd !== exp_mem[addr]) begin
                    n_err++; $display("FAIL rnd_read[%0d]: got %h need %h (x%0d)", k, rd, exp_mem[addr], addr);
                end
            end
        end
    endtask

    task automatic test_rsp_hold_and_reset();
        logic [DW-1:0] rd; int tr, ts, nr; logic aw; logic [AW-1:0] ar;
        idle(Q);
        host_txn(1'b0, 5'd5, 32'h0, 1'b0, rd, tr, ts, nr, aw, ar);
        n_cmp++; if (rd !== exp_mem[5]) begin n_err++; $display("FAIL hold_first_rdata: got %h need %h", rd, exp_mem[5]); end
        for (int c = 0; c < 10; c++) begin
            step();
            @(negedge clk);
            n_cmp++; if ({host_rsp_valid, cpu_stall, host_rsp_rdata} !== {1'b1, 1'b1, exp_mem[5]}) begin
                n_err++; $display("FAIL hold_stable[%0d]: got valid=%b stall=%b rdata=%h need 1/1/%h",
                                  c, host_rsp_valid, cpu_stall, host_rsp_rdata, exp_mem[5]);
            end
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if ({cpu_stall, host_rsp_valid, host_req_ready} !== 3'b000) begin
            n_err++; $display("FAIL async_reset_now: got stall=%b rsp_valid=%b ready=%b need 000", cpu_stall, host_rsp_valid, host_req_ready);
        end
        step();
        n_cmp++; if ({cpu_stall, host_rsp_valid} !== 2'b00) begin
            n_err++; $display("FAIL async_reset_edge: got stall=%b rsp_valid=%b need 00", cpu_stall, host_rsp_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        step();
        host_txn(1'b0, 5'd5, 32'h0, 1'b1, rd, tr, ts, nr, aw, ar);
        n_cmp++; if (tr !== 2 || rd !== exp_mem[5]) begin
            n_err++; $display("FAIL post_reset_read: got ready=%0d rdata=%h need 2/%h", tr, rd, exp_mem[5]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; rf_clr = 1'b1;
        cpu_we = 1'b0; cpu_wR = '0; cpu_wD = '0; cpu_rR1 = '0;
        host_req_valid = 1'b0; host_req_we = 1'b0; host_req_addr = '0; host_req_wdata = '0;
        host_rsp_ready = 1'b0;
        for (int i = 0; i < 32; i++) exp_mem[i] = '0;
        repeat (2) @(posedge clk);
        test_reset();
        test_write_read();
        test_x0();
        test_back_to_back();
        test_core_blocked();
        test_random();
        test_rsp_hold_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
